// File: rtl/seg_scan_ctrl_if.sv
// Bus between the value-producing logic and the seven-segment scan controller.
// master = value producer, slave = seg_scan_ctrl.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic [31:0]               scan_div;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     dps;
    logic                      load;
    logic [NUM_DIGITS-1:0]     an;
    logic [6:0]                seg;
    logic                      dp;
    logic                      frame_done;

    modport master (
        output en, scan_div, digits, dps, load,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  en, scan_div, digits, dps, load,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Common-anode multi-digit seven-segment scan controller with tick divider,
// anti-ghost blanking and frame-aligned double buffering.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 8
) (
    input  logic          clk_in,
    input  logic          RST,
    seg_scan_ctrl_if.slave bus
);
    localparam int IW         = $clog2(NUM_DIGITS);
    localparam int BW         = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [NUM_DIGITS-1:0] ONE_HOT = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        S_OFF,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t                          state;
    logic [IW-1:0]                   idx;
    logic [BW-1:0]                   blank_cnt;
    logic [31:0]                     tick_cnt;
    logic                            tick_pend;
    logic [NUM_DIGITS-1:0][3:0]      shadow_dig;
    logic [NUM_DIGITS-1:0]           shadow_dps;
    logic [NUM_DIGITS-1:0][3:0]      active_dig;
    logic [NUM_DIGITS-1:0]           active_dps;
    logic                            pending;

    logic                  tick;
    logic                  last_idx;
    logic                  advance;
    logic                  wrap;
    logic                  xfer;
    logic [IW-1:0]         idx_next;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [6:0]            cur_seg;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // The divider only runs while scanning, so every enable starts a fresh dwell.
    always_comb begin
        tick     = bus.en && (state != S_OFF) && (tick_cnt >= bus.scan_div);
        last_idx = (idx == IW'(NUM_DIGITS - 1));
        idx_next = last_idx ? '0 : idx + IW'(1);
        advance  = bus.en && (state == S_DRIVE) && (tick || tick_pend);
        wrap     = advance && last_idx;
        xfer     = pending && (wrap || (state == S_OFF));
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS:0] hi_zero;
    always_comb begin
        hi_zero             = '0;
        lz_blank            = '0;
        hi_zero[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            hi_zero[i] = hi_zero[i+1] && (active_dig[i] == 4'h0);
            if (i != 0)
                lz_blank[i] = hi_zero[i] && !active_dps[i];
        end
    end
`else
    always_comb lz_blank = '0;
`endif

    always_comb cur_seg = lz_blank[idx] ? 7'h7F : hex7(active_dig[idx]);

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            state          <= S_OFF;
            idx            <= '0;
            blank_cnt      <= '0;
            tick_cnt       <= '0;
            tick_pend      <= 1'b0;
            shadow_dig     <= '0;
            shadow_dps     <= '0;
            active_dig     <= '0;
            active_dps     <= '0;
            pending        <= 1'b0;
            bus.an         <= '1;
            bus.seg        <= 7'h7F;
            bus.dp         <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;

            if (!bus.en || state == S_OFF || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 32'd1;

            // A load on the wrap cycle lands in shadow and stays pending.
            if (xfer) begin
                active_dig <= shadow_dig;
                active_dps <= shadow_dps;
            end
            if (bus.load) begin
                shadow_dig <= bus.digits;
                shadow_dps <= bus.dps;
                pending    <= 1'b1;
            end else if (xfer) begin
                pending <= 1'b0;
            end

            if (!bus.en) begin
                state     <= S_OFF;
                idx       <= '0;
                blank_cnt <= '0;
                tick_pend <= 1'b0;
            end else begin
                case (state)
                    S_OFF: begin
                        idx       <= '0;
                        blank_cnt <= '0;
                        tick_pend <= 1'b0;
                        state     <= (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
                    end
                    S_BLANK: begin
                        // A tick during blanking is remembered, not dropped.
                        if (tick)
                            tick_pend <= 1'b1;
                        if (blank_cnt == BW'(BLANK_LAST)) begin
                            blank_cnt <= '0;
                            state     <= S_DRIVE;
                        end else begin
                            blank_cnt <= blank_cnt + BW'(1);
                        end
                    end
                    S_DRIVE: begin
                        if (advance) begin
                            idx            <= idx_next;
                            tick_pend      <= 1'b0;
                            bus.frame_done <= wrap;
                            state          <= (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
                        end
                    end
                    default: state <= S_OFF;
                endcase
            end

            // Outputs reflect the state/index registered on the previous edge.
            if (!bus.en || state == S_OFF) begin
                bus.an  <= '1;
                bus.seg <= 7'h7F;
                bus.dp  <= 1'b1;
            end else begin
                bus.an  <= (state == S_DRIVE) ? ~(ONE_HOT << idx) : '1;
                bus.seg <= cur_seg;
                bus.dp  <= ~active_dps[idx];
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected lit runs are queued at stimulus
// time and compared (anode, segments, dp, length, blank gap) as the display scans.
module tb_seg_scan_ctrl;
    localparam int N = 4;
    localparam int B = 2;

    logic clk_in = 1'b0;
    logic RST    = 1'b1;
    always #5 clk_in = ~clk_in;

    seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_ctrl #(.NUM_DIGITS(N), .BLANK_CYCLES(B)) dut (
        .clk_in (clk_in),
        .RST    (RST),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         len;
    } run_t;

    run_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] data, input logic [3:0] d, input int i);
`ifdef LEADING_ZERO_BLANK_EN
        logic hz = 1'b1;
        for (int j = N - 1; j >= i; j--)
            if (data[j*4 +: 4] != 4'h0) hz = 1'b0;
        if (i != 0 && hz && !d[i]) return 7'h7F;
`endif
        return hex7(data[i*4 +: 4]);
    endfunction

    task automatic push_run(input int i, input logic [15:0] data, input logic [3:0] d, input int len);
        run_t r;
        r.an  = ~(4'b0001 << i);
        r.seg = exp_seg(data, d, i);
        r.dp  = ~d[i];
        r.len = len;
        sb_q.push_back(r);
    endtask

    task automatic push_frame(input logic [15:0] data, input logic [3:0] d, input int len);
        for (int i = 0; i < N; i++) push_run(i, data, d, len);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk_in);
            n++;
        end
        mon_on = 1'b0;
        chk("drain", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic wait_fd(input int budget);
        int n = 0;
        logic seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk_in);
            seen = bus.frame_done;
            n++;
        end
        chk("fd_wait", seen, 1);
    endtask

    task automatic wait_an(input logic [3:0] v, input int budget);
        int n = 0;
        logic seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk_in);
            seen = (bus.an == v);
            n++;
        end
        chk("an_wait", seen, 1);
    endtask

    task automatic do_load(input logic [15:0] data, input logic [3:0] d);
        bus.digits = data;
        bus.dps    = d;
        bus.load   = 1'b1;
        @(negedge clk_in);
        bus.load   = 1'b0;
    endtask

    // Run monitor: measures lit runs and the blank gaps between them.
    logic       armed   = 1'b0;
    logic       had_lit = 1'b0;
    logic [3:0] prev_an = 4'hF;
    int         run_len = 0;
    logic [6:0] run_seg = 7'h7F;
    logic       run_dp  = 1'b1;
    run_t       r;

    always @(negedge clk_in) begin
        if (!mon_on) begin
            armed = 1'b0;
        end else if (!armed) begin
            if (bus.an == 4'hF) begin
                armed   = 1'b1;
                had_lit = 1'b0;
                prev_an = bus.an;
                run_len = 1;
            end
        end else if (bus.an != prev_an) begin
            if (prev_an != 4'hF) begin
                if (sb_q.size() == 0) begin
                    chk("extra_run", sb_q.size(), 1);
                end else begin
                    r = sb_q.pop_front();
                    chk("run_an", prev_an, r.an);
                    chk("run_seg", run_seg, r.seg);
                    chk("run_dp", run_dp, r.dp);
                    chk("run_len", run_len, r.len);
                end
                had_lit = 1'b1;
            end else if (had_lit) begin
                chk("gap_len", run_len, B);
            end
            prev_an = bus.an;
            run_seg = bus.seg;
            run_dp  = bus.dp;
            run_len = 1;
        end else begin
            run_len++;
        end
    end

    int fd_len = 0;
    always @(negedge clk_in) begin
        if (bus.frame_done) fd_len++;
        else if (fd_len != 0) begin
            chk("fd_width", fd_len, 1);
            fd_len = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [15:0] pat  [5] = '{16'h0050, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    logic [3:0]  pdps [5] = '{4'b1000, 4'b0001, 4'b0100, 4'b0010, 4'b0000};

    initial begin
        bus.en       = 1'b0;
        bus.scan_div = 32'd9;
        bus.digits   = '0;
        bus.dps      = '0;
        bus.load     = 1'b0;

        // Reset state
        @(negedge clk_in);
        chk("rst_an", bus.an, 4'hF);
        chk("rst_seg", bus.seg, 7'h7F);
        chk("rst_dp", bus.dp, 1);
        chk("rst_fd", bus.frame_done, 0);
        RST = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("off_an", bus.an, 4'hF);

        // 1: frame 0 shows old zeros, 1234 applies after first wrap
        mon_on = 1'b1;
        @(negedge clk_in);
        push_frame(16'h0000, 4'h0, 8);
        push_frame(16'h1234, 4'h0, 8);
        bus.en = 1'b1;
        do_load(16'h1234, 4'h0);
        drain(300);

        // 2: asynchronous reset mid-drive, restart at digit 0 with cleared data
        wait_an(4'hD, 100);
        #2 RST = 1'b1;
        #1;
        chk("arst_an", bus.an, 4'hF);
        chk("arst_seg", bus.seg, 7'h7F);
        chk("arst_dp", bus.dp, 1);
        bus.en = 1'b0;
        repeat (2) @(negedge clk_in);
        RST = 1'b0;
        @(negedge clk_in);
        mon_on = 1'b1;
        push_frame(16'h0000, 4'h0, 8);
        bus.en = 1'b1;
        drain(200);

        // 3: two loads before the wrap, the last one wins
        wait_fd(100);
        @(negedge clk_in);
        do_load(16'hABCD, 4'h0);
        repeat (5) @(negedge clk_in);
        do_load(16'h00F0, 4'h0);
        wait_fd(100);
        mon_on = 1'b1;
        push_frame(16'h00F0, 4'h0, 8);
        drain(200);

        // 4: en dropped mid-frame, then re-enabled
        wait_an(4'hD, 100);
        bus.en = 1'b0;
        @(negedge clk_in);
        chk("endrop_an", bus.an, 4'hF);
        chk("endrop_seg", bus.seg, 7'h7F);
        repeat (2) @(negedge clk_in);
        mon_on = 1'b1;
        push_frame(16'h00F0, 4'h0, 8);
        bus.en = 1'b1;
        drain(200);

        // 5: scan_div shrinks from 100 to 3 while tick_cnt = 50
        bus.en       = 1'b0;
        bus.scan_div = 32'd100;
        repeat (2) @(negedge clk_in);
        mon_on = 1'b1;
        push_run(0, 16'h00F0, 4'h0, 49);
        for (int i = 1; i < N; i++) push_run(i, 16'h00F0, 4'h0, 2);
        bus.en = 1'b1;
        repeat (51) @(negedge clk_in);
        bus.scan_div = 32'd3;
        drain(200);

        // 6: loads while dark transfer before the scan starts; decode sweep
        for (int p = 0; p < 5; p++) begin
            bus.en = 1'b0;
            @(negedge clk_in);
            do_load(pat[p], pdps[p]);
            @(negedge clk_in);
            mon_on = 1'b1;
            push_frame(pat[p], pdps[p], 2);
            bus.en = 1'b1;
            drain(100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
